// File: rtl/spi_reg_master_pkg.sv
// Shared constants and state encoding for the
// SPI register-frame initiator.
package spi_reg_master_pkg;

  localparam int FRAME_W      = 16;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;
  localparam int HALF_PERIODS = 32;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LEAD  = 3'd1;
  localparam state_t SHIFT = 3'd2;
  localparam state_t TRAIL = 3'd3;
  localparam state_t GAP   = 3'd4;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] lo;
    lo = (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}};
    return {rw, addr, lo};
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Host request/response and SPI pin bundle
// for the register-frame initiator.
interface spi_reg_master_if;
  import spi_reg_master_pkg::*;

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;

  modport master (
    input  start, rw, addr, wdata, spi_miso,
    output busy, done, rdata,
    output spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    output start, rw, addr, wdata, spi_miso,
    input  busy, done, rdata,
    input  spi_cs_n, spi_sclk, spi_mosi
  );

endinterface

// File: rtl/spi_master_tick.sv
// Half-period timer: DIV clk cycles per phase,
// held at zero while cleared.
module spi_master_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic end_of_half,
  output logic last_cycle
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign last_cycle  = (cnt == CW'(DIV - 1));
  assign end_of_half = last_cycle & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || last_cycle)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator issuing one 16-bit
// register read/write frame per request.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int DIV = 4
) (
  input logic              clk,
  input logic              rst,
  spi_reg_master_if.master bus
);

  localparam int HW = $clog2(HALF_PERIODS);

  state_t             state;
  logic [FRAME_W-1:0] tx;
  logic [DATA_W-1:0]  rx;
  logic [HW-1:0]      half;
  logic [1:0]         sync;
  logic               rw_q;
  logic               eoh;
  logic               last;

  spi_master_tick #(.DIV(DIV)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == IDLE),
    .end_of_half (eoh),
    .last_cycle  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sync <= '0;
    else
      sync <= {sync[0], bus.spi_miso};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx           <= '0;
      rx           <= '0;
      half         <= '0;
      rw_q         <= RW_READ;
      bus.spi_cs_n <= 1'b1;
      bus.spi_sclk <= 1'b0;
      bus.spi_mosi <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LEAD;
            tx           <= make_frame(bus.rw, bus.addr, bus.wdata);
            rw_q         <= bus.rw;
            half         <= '0;
            bus.busy     <= 1'b1;
            bus.spi_cs_n <= 1'b0;
            bus.spi_mosi <= bus.rw;
          end
        end
        LEAD: begin
          if (eoh)
            state <= SHIFT;
        end
        SHIFT: begin
          // sample at the tail of each high half
          if (last && bus.spi_sclk)
            rx <= {rx[DATA_W-2:0], sync[1]};
          if (eoh) begin
            bus.spi_sclk <= ~bus.spi_sclk;
            half         <= half + HW'(1);
            if (bus.spi_sclk) begin
              if (half == HW'(HALF_PERIODS - 1)) begin
                state <= TRAIL;
              end else begin
                tx           <= tx << 1;
                bus.spi_mosi <= tx[FRAME_W-2];
              end
            end
          end
        end
        TRAIL: begin
          if (eoh) begin
            state        <= GAP;
            bus.spi_cs_n <= 1'b1;
            bus.spi_mosi <= 1'b0;
          end
        end
        GAP: begin
          if (eoh) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (rw_q == RW_READ)
              bus.rdata <= rx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Random and directed frames on DIV=4 and DIV=6 instances,
// scored against a frame-level reference model.
module tb_spi_reg_master;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  first;
    logic [7:0]  resp;
    logic [7:0]  rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;

  logic       cs_w   [2];
  logic       sclk_w [2];
  logic       mosi_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] rdata_w[2];
  logic       miso_r [2];

  exp_t       exp_q[$];
  logic [7:0] model_rd = '0;
  int         idx[2];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       fin_req = 1'b0;
  logic       fin_done = 1'b0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g
      spi_reg_master_if bus ();
      assign bus.start    = start;
      assign bus.rw       = rw;
      assign bus.addr     = addr;
      assign bus.wdata    = wdata;
      assign bus.spi_miso = miso_r[gi];
      assign cs_w[gi]     = bus.spi_cs_n;
      assign sclk_w[gi]   = bus.spi_sclk;
      assign mosi_w[gi]   = bus.spi_mosi;
      assign busy_w[gi]   = bus.busy;
      assign done_w[gi]   = bus.done;
      assign rdata_w[gi]  = bus.rdata;
      spi_reg_master #(.DIV(4 + 2 * gi)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // monitor, responder and scoreboard consumer
  logic        pcs[2], psc[2], pend[2];
  logic        have_rise[2], hok[2], rchk[2];
  int          fs[2], lchg[2], crise[2], np[2], clow[2];
  logic [15:0] mw[2], rsr[2];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int d;
      exp_t e;
      d = 4 + 2 * i;
      if (rst) begin
        if (!rchk[i])
          chk($sformatf("reset_out_div%0d", d),
              32'({cs_w[i], sclk_w[i], mosi_w[i],
                   busy_w[i], done_w[i], rdata_w[i]}),
              32'h1000);
        rchk[i]      = 1'b1;
        idx[i]       = exp_q.size();
        pend[i]      = 1'b0;
        miso_r[i]    = 1'b0;
        pcs[i]       = 1'b1;
        psc[i]       = 1'b0;
        have_rise[i] = 1'b0;
      end else begin
        rchk[i] = 1'b0;
        if (pend[i]) begin
          rsr[i]    = rsr[i] << 1;
          miso_r[i] = rsr[i][15];
          pend[i]   = 1'b0;
        end
        if (!cs_w[i] && pcs[i]) begin
          if (have_rise[i])
            chk($sformatf("cs_gap_ok_div%0d", d),
                32'(cyc - crise[i] >= d), 32'd1);
          rsr[i] = 16'h0000;
          if (idx[i] < exp_q.size())
            rsr[i] = {exp_q[idx[i]].first, exp_q[idx[i]].resp};
          miso_r[i] = rsr[i][15];
          fs[i]   = cyc;
          lchg[i] = cyc;
          mw[i]   = '0;
          np[i]   = 0;
          hok[i]  = 1'b1;
        end
        if (!cs_w[i] && sclk_w[i] != psc[i]) begin
          if (sclk_w[i]) begin
            mw[i] = {mw[i][14:0], mosi_w[i]};
            np[i]++;
          end else begin
            pend[i] = 1'b1;
          end
          if (sclk_w[i] && np[i] == 1)
            hok[i] &= (cyc - fs[i] == 2 * d);
          else
            hok[i] &= (cyc - lchg[i] == d);
          lchg[i] = cyc;
        end
        if (cs_w[i] && !pcs[i]) begin
          crise[i]     = cyc;
          have_rise[i] = 1'b1;
          clow[i]      = cyc - fs[i];
          hok[i]      &= (cyc - lchg[i] == d);
        end
        if (done_w[i]) begin
          if (idx[i] >= exp_q.size()) begin
            chk($sformatf("unexpected_done_div%0d", d),
                32'd1, 32'd0);
          end else begin
            e = exp_q[idx[i]];
            idx[i]++;
            chk($sformatf("mosi_word_div%0d", d),
                32'(mw[i]), 32'(e.word));
            chk($sformatf("sclk_pulses_div%0d", d),
                32'(np[i]), 32'd16);
            chk($sformatf("cs_low_len_div%0d", d),
                32'(clow[i]), 32'(34 * d));
            chk($sformatf("done_cycle_div%0d", d),
                32'(cyc - fs[i]), 32'(35 * d));
            chk($sformatf("half_period_div%0d", d),
                32'(hok[i]), 32'd1);
            chk($sformatf("rdata_div%0d", d),
                32'(rdata_w[i]), 32'(e.rdata));
            chk($sformatf("busy_at_done_div%0d", d),
                32'(busy_w[i]), 32'd0);
          end
        end
        pcs[i] = cs_w[i];
        psc[i] = sclk_w[i];
      end
    end
    if (fin_req && !fin_done) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("frames_done_div%0d", 4 + 2 * i),
            32'(idx[i]), 32'(exp_q.size()));
      fin_done = 1'b1;
    end
  end

  task automatic push(input logic       r,
                      input logic [6:0] a,
                      input logic [7:0] w,
                      input logic [7:0] f,
                      input logic [7:0] rsp);
    exp_t e;
    e.word  = {r, a, (r ? w : 8'h00)};
    e.first = f;
    e.resp  = rsp;
    if (!r)
      model_rd = rsp;
    e.rdata = model_rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_w[0] || busy_w[1]) && n < 2000);
    if (n >= 2000) begin
      $display("FAIL idle_timeout: got busy want idle");
      $fatal(1, "timeout");
    end
  endtask

  task automatic drive(input logic       r,
                       input logic [6:0] a,
                       input logic [7:0] w);
    rw    = r;
    addr  = a;
    wdata = w;
  endtask

  task automatic issue(input logic       r,
                       input logic [6:0] a,
                       input logic [7:0] w,
                       input logic [7:0] f,
                       input logic [7:0] rsp);
    wait_idle();
    drive(r, a, w);
    start = 1'b1;
    push(r, a, w, f, rsp);
    @(negedge clk);
    start = 1'b0;
    drive(~r, ~a, ~w);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    issue(1'b1, 7'h05, 8'hA5, 8'h00, 8'h00);
    issue(1'b0, 7'h12, 8'($urandom), 8'($urandom), 8'h3C);

    // a start mid-frame must be ignored
    issue(1'b1, 7'($urandom), 8'($urandom), 8'h00, 8'h00);
    repeat (40) @(negedge clk);
    drive(1'b0, 7'h7F, 8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // back-to-back: start held through the done cycle
    wait_idle();
    drive(1'b0, 7'($urandom), 8'($urandom));
    start = 1'b1;
    push(rw, addr, wdata, 8'($urandom), 8'($urandom));
    @(negedge clk);
    drive(1'b1, 7'($urandom), 8'($urandom));
    push(rw, addr, wdata, 8'($urandom), 8'($urandom));
    n = 0;
    while (!done_w[1] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL b2b_timeout: got no done want done");
      $fatal(1, "timeout");
    end
    @(negedge clk);
    start = 1'b0;

    for (int k = 0; k < 5; k++)
      issue(1'($urandom), 7'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom));

    issue(1'b0, 7'h33, 8'h00, 8'h5A, 8'hC3);

    // reset while shifting, then a clean write
    issue(1'b1, 7'h05, 8'hA5, 8'h00, 8'h00);
    repeat (52) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_rd = 8'h00;
    issue(1'b1, 7'h05, 8'hA5, 8'h00, 8'h00);
    issue(1'b0, 7'h12, 8'h00, 8'h81, 8'h3C);

    wait_idle();
    repeat (5) @(negedge clk);
    fin_req = 1'b1;
    n = 0;
    while (!fin_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI mode-0 initiator that performs single-register read/write frames against the SPI/I2C register bank. It is the other end of the bank's SPI responder interface.
- Used for on-chip loopback and self-test, and as the reference controller for bench and firmware models.
- A host requests one frame at a time with start/busy/done. The block generates cs_n, sclk and mosi, and captures miso.

Parameters:
- DIV, 4, sclk half-period in clk cycles; legal values are 4 and above.
- ADDR_W, 7, register address width; fixed by the frame format.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active high
- start  input  1  request a frame; sampled only in IDLE
- rw  input  1  1 = write, 0 = read; latched when start is accepted
- addr  input  7  register address; latched when start is accepted
- wdata  input  8  write data; latched when start is accepted
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when a frame completes
- rdata  output  8  read data; updated only when a read frame completes
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  serial clock, idle low
- spi_mosi  output  1  serial data out
- spi_miso  input  1  serial data in; asynchronous to clk

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0
  - busy=0, done=0, rdata=0x00
  - state returns to IDLE
- Frame format: 16 bits, MSB first, shift register = {rw, addr[6:0], wdata[7:0]}. On a read, the low byte transmitted is 0x00.
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
  - Each timed phase uses a DIV-cycle counter.
- Timing is counted from cycle 0, the clk edge on which start is sampled high in IDLE:
  - Cycles 1..DIV, LEAD: spi_cs_n=0, busy=1, sclk low, mosi = frame bit 15.
  - Cycles DIV+1..33*DIV, SHIFT: 32 half-periods of DIV cycles each, low then high, 16 sclk pulses in total.
    - sclk rises at the start of every high half-period.
    - mosi changes only at the start of a low half-period, presenting the next bit.
  - Cycles 33*DIV+1..34*DIV, TRAIL: sclk low, cs_n still 0.
  - Cycles 34*DIV+1..35*DIV, GAP: cs_n=1, mosi=0, busy remains 1.
  - Cycle 35*DIV+1: done=1 for this cycle only, busy=0, state=IDLE.
- MISO capture:
  - spi_miso passes through a 2-flop synchronizer.
  - The synchronized value is shifted in on the last clk cycle of each sclk-high half-period.
  - 16 bits are captured; the last 8 form the read byte.
- rdata is loaded with the read byte in the done cycle of read frames only. Write frames leave rdata unchanged.
- start while busy=1 is ignored; there is no queueing and the latched inputs are not altered.
- start in the done cycle is accepted, because that cycle is IDLE. The new frame's LEAD begins on the next cycle.
- Inputs rw/addr/wdata may change freely once the frame is accepted.
- The sclk phase and the TRAIL/GAP phases come from the same half-period counter. This guarantees at least DIV cycles of cs_n high between frames.

Decomposition:
- Package spi_reg_master_pkg contains:
  - state enum: IDLE, LEAD, SHIFT, TRAIL, GAP
  - FRAME_W=16, RW_WRITE=1'b1, RW_READ=1'b0
  - HALF_PERIODS=32
- Sub-module spi_master_tick: DIV-cycle half-period counter.
  - Asserts a one-cycle end_of_half tick.
  - Asserts a last_cycle flag, used for the MISO sample point.
  - Cleared whenever the FSM changes phase.
- The 2-flop synchronizer stays inline.

Test Plan:
- Write test, DIV=4: rw=1, addr=0x05, wdata=0xA5.
  - MOSI captured on sclk rises = 0x85A5.
  - 16 sclk pulses, each half-period 4 cycles; cs_n low from cycle 1 to 136.
  - done at cycle 141; rdata stays 0x00.
- Read test: responder model returns 0x3C in the second byte; rw=0, addr=0x12.
  - MOSI = 0x1200.
  - rdata=0x3C in the done cycle and held afterwards.
- Busy-ignore test: pulse start with addr=0x7F mid-frame.
  - The current frame's bits are unchanged.
  - Only one done pulse occurs; no second frame starts.
- Back-to-back test: hold start high across the done cycle.
  - The second frame's cs_n falls at done+1.
  - cs_n is high for at least 4 cycles between frames.
- Reset-mid-frame test: assert rst during SHIFT at bit 9.
  - Outputs go to reset values immediately; no done pulse.
  - A fresh write afterwards completes correctly (0x85A5 again).
- DIV=6 variant: repeat the read test.
  - Half-periods are 6 cycles; done at cycle 211.
  - rdata is correct with miso changing 1 cycle after each sclk fall.
